noc_input_port: RTL

- Router-side receiver sitting directly downstream of the node's network interface (NI).
- Accepts single-flit packets from the NI over the req / channel_busy handshake, checks the MSB parity bit, and buffers good flits in a small FIFO.
- Computes the XY output direction for each flit in the 2x2 mesh and presents head-of-queue flits to the router switch with a valid/grant handshake.
- Flit width W = `HDR_SZ + `PL_SZ + `ADDR_SZ, taken from constants.v.
- Flit layout, MSB to LSB: parity, header, payload, dest; dest = item[`ADDR_SZ-1:0].

---
 rtl/noc_input_port_if.sv | 31 +++
 rtl/noc_input_port.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/noc_input_port_if.sv
// Handshake bundle between the NI, the input port and the router switch.
// Flit width comes from the HDR_SZ/PL_SZ/ADDR_SZ constants (defaults below if not predefined).
`ifndef HDR_SZ
`define HDR_SZ 4
`endif
`ifndef PL_SZ
`define PL_SZ 8
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

interface noc_input_port_if;
  logic [`HDR_SZ+`PL_SZ+`ADDR_SZ-1:0] item_in;
  logic                               req;
  logic                               channel_busy;
  logic [`HDR_SZ+`PL_SZ+`ADDR_SZ-1:0] out_item;
  logic                               out_valid;
  logic [2:0]                         out_dir;
  logic                               out_grant;

  modport slave (
    input  item_in, req, out_grant,
    output channel_busy, out_item, out_valid, out_dir
  );

  modport master (
    output item_in, req, out_grant,
    input  channel_busy, out_item, out_valid, out_dir
  );
endinterface

// File: rtl/noc_input_port.sv
// Router input port: parity-checked NI receiver, FWFT flit FIFO and XY route lookup.
// Optional feature macro: PARITY_CHECK_EN (drop flits failing even parity).
`ifndef HDR_SZ
`define HDR_SZ 4
`endif
`ifndef PL_SZ
`define PL_SZ 8
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

module noc_input_port #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [`ADDR_SZ-1:0] id,
  noc_input_port_if.slave     bus,
  output logic                parity_err,
  output logic [CNT_W-1:0]    err_cnt,
  output logic [CNT_W-1:0]    ovf_cnt
);

  localparam int unsigned W     = `HDR_SZ + `PL_SZ + `ADDR_SZ;
  localparam int unsigned AW    = `ADDR_SZ;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] BUSY_C  = (PTR_W+1)'(DEPTH - 1);

  typedef enum logic [2:0] {
    DIR_LOCAL = 3'd0,
    DIR_EAST  = 3'd1,
    DIR_WEST  = 3'd2,
    DIR_NORTH = 3'd3,
    DIR_SOUTH = 3'd4
  } dir_e;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic             bad, pop, push, ovf_drop;

`ifdef PARITY_CHECK_EN
  assign bad = bus.req & (^bus.item_in);
`else
  assign bad = 1'b0;
`endif

  always_comb begin
    pop      = out_valid_q & bus.out_grant;
    // a full FIFO still takes the flit when the head leaves in the same cycle
    push     = bus.req & ~bad & ((count_q < DEPTH_C) | pop);
    ovf_drop = bus.req & ~bad & ~push;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.item_in;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
    out_valid_d = (count_d != '0);
    busy_d      = (count_d >= BUSY_C);
    ovf_cnt_d   = (ovf_drop && ovf_cnt_q != '1) ? ovf_cnt_q + CNT_W'(1) : ovf_cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ovf_cnt_q   <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef PARITY_CHECK_EN
  logic             parity_err_q, parity_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    parity_err_d = bad;
    err_cnt_d    = (bad && err_cnt_q != '1) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_err_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      parity_err_q <= parity_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign parity_err = parity_err_q;
  assign err_cnt    = err_cnt_q;
`else
  assign parity_err = 1'b0;
  assign err_cnt    = '0;
`endif

  assign bus.out_item     = mem_q[rd_ptr_q];
  assign bus.out_valid    = out_valid_q;
  assign bus.channel_busy = busy_q;
  assign ovf_cnt          = ovf_cnt_q;

  // XY routing on the low two address bits; x resolved before y
  logic [AW-1:0] dest;
  logic          mx, my, dx, dy;
  dir_e          dir;
  logic          unused_addr_bits;

  assign dest             = bus.out_item[AW-1:0];
  assign unused_addr_bits = ^{id, dest};

  always_comb begin
    mx = id[0];
    my = id[1];
    dx = dest[0];
    dy = dest[1];
    if (dx != mx)      dir = (dx > mx) ? DIR_EAST  : DIR_WEST;
    else if (dy != my) dir = (dy > my) ? DIR_SOUTH : DIR_NORTH;
    else               dir = DIR_LOCAL;
  end

  assign bus.out_dir = dir;

endmodule
